// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// State encodings, grant identifiers, wait-state bounds and the
// helper that turns a latency parameter into a counter load value.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DMA = 1'b1;

  // Legal range of memory read latency; the wait counter is sized for MAX.
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W       = 4;

  // Counter load for the ACCESS state. Out-of-range latencies are clamped
  // so a bad parameter cannot wrap the counter into a very long access.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    int l;
    l = lat;
    if (l < MEM_LAT_MIN) l = MEM_LAT_MIN;
    if (l > MEM_LAT_MAX) l = MEM_LAT_MAX;
    return CNT_W'(l - 1);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Winner select for the memory port arbiter.
// Config macro: ARB_ROUND_ROBIN_EN
//   defined   - a tie goes to the requester that did not win last time
//   undefined - fixed priority, the CPU wins every tie
// A single requester always wins regardless of the macro.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

`ifndef ARB_ROUND_ROBIN_EN
  // last_grant is kept by the FSM in both builds but only consulted here
  // when round robin is enabled.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Combinational winner select
  always_comb begin
    valid = cpu_req | dma_req;
    grant = GNT_CPU;
    if (cpu_req && dma_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      grant = (last_grant == GNT_CPU) ? GNT_DMA : GNT_CPU;
`else
      grant = GNT_CPU;
`endif
    end else if (dma_req) begin
      grant = GNT_DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the CPU memory
// interface and a DMA/loader port. Each grant is one complete access:
// address issue, MEM_LAT wait cycles, read-data capture, one-cycle ack.
// Config macro: ARB_ROUND_ROBIN_EN (tie policy, resolved inside arb_pick).
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ARB_IDLE   | no access; pick a winner and latch its request
//   ARB_ACCESS | address/wdata on the memory bus, wait counter running,
//              | mem_we only in the first cycle, rdata captured at 0
//   ARB_DONE   | one-cycle ack to the winner, last_grant updated
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N       = 32,
  parameter int AW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [N-1:0]  cpu_wdata,
  output logic          cpu_ack,
  output logic [N-1:0]  cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [N-1:0]  dma_wdata,
  output logic          dma_ack,
  output logic [N-1:0]  dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  output logic          mem_we,
  input  logic [N-1:0]  mem_rdata,
  output logic          busy
);

  localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]    addr_q;
  logic [N-1:0]     wdata_q;
  logic             we_q;
  logic             gnt_q;
  logic             last_grant_q;
  logic [N-1:0]     rdata_q;

  logic             pick_valid;
  logic             pick_grant;

  arb_pick u_pick (
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (pick_valid) state_d = ARB_ACCESS;
      ARB_ACCESS: if (cnt_q == '0) state_d = ARB_DONE;
      ARB_DONE:   state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  // Outputs decoded from state; mem_we clears as soon as the async reset
  // drops the state back to IDLE. The counter only equals its load value
  // in the first ACCESS cycle, which limits the write strobe to one cycle.
  always_comb begin
    busy    = (state_q != ARB_IDLE);
    mem_we  = 1'b0;
    cpu_ack = 1'b0;
    dma_ack = 1'b0;
    if (state_q == ARB_ACCESS && cnt_q == LAT_LOAD) mem_we = we_q;
    if (state_q == ARB_DONE) begin
      cpu_ack = (gnt_q == GNT_CPU);
      dma_ack = (gnt_q == GNT_DMA);
    end
  end

  // Request latch, wait counter, read-data capture and grant history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      gnt_q        <= GNT_CPU;
      last_grant_q <= GNT_DMA;
      rdata_q      <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            gnt_q <= pick_grant;
            cnt_q <= LAT_LOAD;
            if (pick_grant == GNT_CPU) begin
              addr_q  <= cpu_addr;
              wdata_q <= cpu_wdata;
              we_q    <= cpu_we;
            end else begin
              addr_q  <= dma_addr;
              wdata_q <= dma_wdata;
              we_q    <= dma_we;
            end
          end
        end
        ARB_ACCESS: begin
          if (cnt_q == '0) rdata_q <= mem_rdata;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ARB_DONE: last_grant_q <= gnt_q;
        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = rdata_q;
  assign dma_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change and outputs are
// sampled on the falling edge; one DUT uses MEM_LAT=1 with a small
// combinational-read memory, a second uses MEM_LAT=3 with read data
// driven cycle by cycle. Tie expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

  localparam int N  = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [N-1:0]  cpu_wdata = '0;
  logic          dma_req = 1'b0, dma_we = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [N-1:0]  dma_wdata = '0;
  logic          cpu_ack, dma_ack, mem_we, busy;
  logic [N-1:0]  cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  logic          l3_cpu_req = 1'b0;
  logic [AW-1:0] l3_cpu_addr = '0;
  logic [N-1:0]  l3_cpu_wdata = '0;
  logic [N-1:0]  l3_rdata_in = 32'hBAD0_0000;
  logic          l3_cpu_ack, l3_dma_ack, l3_mem_we, l3_busy;
  logic [N-1:0]  l3_cpu_rdata, l3_dma_rdata, l3_mem_wdata;
  logic [AW-1:0] l3_mem_addr;

  logic [N-1:0]  mem [0:255];
  logic          pre_we = 1'b0;
  logic [7:0]    pre_addr = '0;
  logic [N-1:0]  pre_data = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N(N), .AW(AW), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  mem_port_arbiter #(.N(N), .AW(AW), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(l3_cpu_req), .cpu_we(1'b0), .cpu_addr(l3_cpu_addr), .cpu_wdata(l3_cpu_wdata),
    .cpu_ack(l3_cpu_ack), .cpu_rdata(l3_cpu_rdata),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr('0), .dma_wdata('0),
    .dma_ack(l3_dma_ack), .dma_rdata(l3_dma_rdata),
    .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata), .mem_we(l3_mem_we), .mem_rdata(l3_rdata_in),
    .busy(l3_busy)
  );

  // Bench memory: combinational read, synchronous write, plus a preload path.
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  task automatic test_reset();
    pre_we = 1'b1; pre_addr = 8'h10; pre_data = 32'hDEAD_BEEF;
    @(negedge clk);
    pre_we = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    total++; if ({cpu_ack, dma_ack} !== 2'b00) begin bad++; $display("FAIL rst_acks: got %b want 00", {cpu_ack, dma_ack}); end
    total++; if (mem_addr !== '0 || mem_wdata !== '0) begin bad++; $display("FAIL rst_latch: got addr %h wdata %h want 0 0", mem_addr, mem_wdata); end
    total++; if (cpu_rdata !== '0) begin bad++; $display("FAIL rst_rdata: got %h want 0", cpu_rdata); end
    total++; if (l3_busy !== 1'b0) begin bad++; $display("FAIL rst_l3_busy: got %b want 0", l3_busy); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    @(negedge clk);
    total++; if (busy !== 1'b1 || mem_addr !== 32'h10) begin bad++; $display("FAIL rd_access: got busy %b addr %h want 1 10", busy, mem_addr); end
    total++; if (mem_we !== 1'b0 || cpu_ack !== 1'b0) begin bad++; $display("FAIL rd_access_we_ack: got we %b ack %b want 0 0", mem_we, cpu_ack); end
    @(negedge clk);
    total++; if (cpu_ack !== 1'b1 || dma_ack !== 1'b0) begin bad++; $display("FAIL rd_ack: got cpu %b dma %b want 1 0", cpu_ack, dma_ack); end
    total++; if (cpu_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_data: got %h want deadbeef", cpu_rdata); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rd_done_we: got %b want 0", mem_we); end
    cpu_req = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || cpu_ack !== 1'b0) begin bad++; $display("FAIL rd_idle: got busy %b ack %b want 0 0", busy, cpu_ack); end
  endtask

  task automatic test_dma_write();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_wdata = 32'h1234_5678;
    @(negedge clk);
    total++; if (mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h1234_5678) begin
      bad++; $display("FAIL wr_strobe: got we %b addr %h data %h want 1 20 12345678", mem_we, mem_addr, mem_wdata); end
    total++; if (dma_ack !== 1'b0) begin bad++; $display("FAIL wr_early_ack: got %b want 0", dma_ack); end
    @(negedge clk);
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL wr_we_one_cycle: got %b want 0", mem_we); end
    total++; if (dma_ack !== 1'b1 || cpu_ack !== 1'b0) begin bad++; $display("FAIL wr_ack: got dma %b cpu %b want 1 0", dma_ack, cpu_ack); end
    dma_req = 1'b0; dma_we = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
    @(negedge clk);
    @(negedge clk);
    total++; if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h1234_5678) begin bad++; $display("FAIL wr_readback: got ack %b data %h want 1 12345678", cpu_ack, cpu_rdata); end
    total++; if (dma_rdata !== 32'h1234_5678) begin bad++; $display("FAIL wr_shared_rdata: got %h want 12345678", dma_rdata); end
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lat3();
    int busy_cycles;
    busy_cycles = 0;
    l3_cpu_req = 1'b1; l3_cpu_addr = 32'h40; l3_cpu_wdata = 32'hA5A5_A5A5;
    l3_rdata_in = 32'hBAD0_0001;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (l3_busy === 1'b1) busy_cycles++;
      if (c == 1) begin
        total++; if (l3_mem_addr !== 32'h40 || l3_mem_wdata !== 32'hA5A5_A5A5 || l3_mem_we !== 1'b0) begin
          bad++; $display("FAIL l3_bus: got addr %h wdata %h we %b want 40 a5a5a5a5 0", l3_mem_addr, l3_mem_wdata, l3_mem_we); end
        l3_rdata_in = 32'hBAD0_0002;
      end else if (c == 2) begin
        l3_rdata_in = 32'hBAD0_0003;
      end else if (c == 3) begin
        total++; if (l3_cpu_ack !== 1'b0) begin bad++; $display("FAIL l3_early_ack: got %b want 0", l3_cpu_ack); end
        l3_rdata_in = 32'hCAFE_F00D;
      end else if (c == 4) begin
        total++; if (l3_cpu_ack !== 1'b1 || l3_dma_ack !== 1'b0) begin bad++; $display("FAIL l3_ack: got cpu %b dma %b want 1 0", l3_cpu_ack, l3_dma_ack); end
        total++; if (l3_cpu_rdata !== 32'hCAFE_F00D || l3_dma_rdata !== 32'hCAFE_F00D) begin
          bad++; $display("FAIL l3_data: got %h %h want cafef00d", l3_cpu_rdata, l3_dma_rdata); end
        l3_rdata_in = 32'hBAD0_0004;
        l3_cpu_req = 1'b0;
      end else begin
        total++; if (l3_cpu_ack !== 1'b0 || l3_cpu_rdata !== 32'hCAFE_F00D) begin
          bad++; $display("FAIL l3_hold: got ack %b data %h want 0 cafef00d", l3_cpu_ack, l3_cpu_rdata); end
      end
    end
    total++; if (busy_cycles != 4) begin bad++; $display("FAIL l3_busy_len: got %0d want 4", busy_cycles); end
  endtask

  task automatic test_round_robin();
    int n_cpu, n_dma, slot;
    logic exp_cpu;
    n_cpu = 0; n_dma = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (cpu_ack === 1'b1) n_cpu++;
      if (dma_ack === 1'b1) n_dma++;
      if (c % 3 == 2) begin
        slot = (c - 2) / 3;
`ifdef ARB_ROUND_ROBIN_EN
        exp_cpu = (slot % 2 == 0);
`else
        exp_cpu = 1'b1;
`endif
        total++; if (cpu_ack !== exp_cpu || dma_ack !== ~exp_cpu) begin
          bad++; $display("FAIL tie_slot%0d: got cpu %b dma %b want cpu %b dma %b", slot, cpu_ack, dma_ack, exp_cpu, ~exp_cpu); end
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    total++; if (n_cpu != 3 || n_dma != 3) begin bad++; $display("FAIL tie_counts: got cpu %0d dma %0d want 3 3", n_cpu, n_dma); end
`else
    total++; if (n_cpu != 6 || n_dma != 0) begin bad++; $display("FAIL tie_counts: got cpu %0d dma %0d want 6 0", n_cpu, n_dma); end
`endif
    @(negedge clk);
  endtask

  task automatic test_req_drop();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h10;
    @(negedge clk);
    dma_req = 1'b0;
    @(negedge clk);
    total++; if (dma_ack !== 1'b1 || dma_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL drop_ack: got ack %b data %h want 1 deadbeef", dma_ack, dma_rdata); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || dma_ack !== 1'b0) begin bad++; $display("FAIL drop_idle: got busy %b ack %b want 0 0", busy, dma_ack); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_stay_idle: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h30; dma_wdata = 32'h55AA_55AA;
    @(negedge clk);
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL rmid_strobe: got %b want 1", mem_we); end
    #1 rst = 1'b1;
    #1;
    total++; if (mem_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_async: got we %b busy %b want 0 0", mem_we, busy); end
    dma_req = 1'b0; dma_we = 1'b0;
    @(negedge clk);
    total++; if (dma_ack !== 1'b0 || mem_addr !== '0) begin bad++; $display("FAIL rmid_no_ack: got ack %b addr %h want 0 0", dma_ack, mem_addr); end
    rst = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
    @(negedge clk);
    total++; if (busy !== 1'b1 || mem_addr !== 32'h10) begin bad++; $display("FAIL rmid_tie_addr: got busy %b addr %h want 1 10", busy, mem_addr); end
    @(negedge clk);
    total++; if (cpu_ack !== 1'b1 || dma_ack !== 1'b0) begin bad++; $display("FAIL rmid_tie_ack: got cpu %b dma %b want 1 0", cpu_ack, dma_ack); end
    cpu_req = 1'b0; dma_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_lat3();
    test_round_robin();
    test_req_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the single-port synchronous instruction/data memory between the multicycle CPU control path and a DMA/loader port. Each granted requester gets one complete memory access (address issue, configurable wait states, read-data capture, one-cycle acknowledge). The arbiter sits between the CPU's IorD-muxed memory interface and the memory macro, replacing the direct connection.

## Interface
- N, 32, data width
- AW, 32, address width
- MEM_LAT, 1, memory read latency in cycles (1..15); length of the ACCESS state
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req / dma_req  in  1  access request; held high until matching ack
- cpu_we / dma_we  in  1  1 = write, 0 = read; stable while req high
- cpu_addr / dma_addr  in  AW  word address; stable while req high
- cpu_wdata / dma_wdata  in  N  write data; stable while req high
- cpu_ack / dma_ack  out  1  one-cycle pulse: access complete
- cpu_rdata / dma_rdata  out  N  read data, valid in the ack cycle (both driven from one shared register)
- mem_addr  out  AW  memory address
- mem_wdata  out  N  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  N  memory read data, MEM_LAT cycles after address
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, DONE (encoding in package).
- IDLE: if any req high, choose winner, latch winner's addr/wdata/we into internal registers, load wait counter with MEM_LAT-1, go ACCESS. Else stay.
- ACCESS: mem_addr/mem_wdata driven from latched registers; mem_we = latched we only in the first ACCESS cycle. Counter decrements each cycle; when 0, capture mem_rdata into rdata register, go DONE.
- DONE: pulse winner's ack; rdata register holds value; go IDLE. Also update last_grant.
- Tie (both req in IDLE): resolved per Configuration. Single requester always wins.
- Request dropped before ack: illegal. The access still completes and ack still pulses.
- Write access: rdata register is still loaded (value irrelevant); ack timing is identical to a read.
- Outputs when not in ACCESS: mem_we = 0; mem_addr/mem_wdata hold the last latched values.

## Timing
- Reset (async, immediate): state = IDLE, counter = 0, last_grant = DMA (CPU wins first tie), latched addr/wdata/we = 0, rdata register = 0, all acks = 0, mem_we = 0, busy = 0.
- Reset mid-access aborts without ack. mem_we drops in the same cycle rst rises.
- Request sampled in IDLE cycle T. ACCESS occupies cycles T+1 .. T+MEM_LAT. DONE/ack occurs in cycle T+MEM_LAT+1.
- With MEM_LAT = 1, ack follows 2 cycles after request.
- Requester deasserts req in the cycle after ack. If req is still high in the following IDLE cycle, it is treated as a new request.
- Maximum throughput: one access per MEM_LAT+2 cycles. The mandatory IDLE bubble is intentional.
- Requests arriving in ACCESS or DONE wait; they are evaluated in the next IDLE cycle.

## Configuration
- Macro `ARB_ROUND_ROBIN_EN`:
  - Defined: ties go to the requester not in last_grant. Both requesters are serviced alternately under continuous contention.
  - Undefined: fixed priority, CPU always wins ties. last_grant is still maintained but unused. The DMA port can starve.

## Structure
- Package mem_arb_pkg:
  - state encodings ARB_IDLE, ARB_ACCESS, ARB_DONE
  - grant IDs GNT_CPU = 1'b0, GNT_DMA = 1'b1
  - MEM_LAT bounds constant
- Sub-module arb_pick: combinational winner select from (cpu_req, dma_req, last_grant). Contains the `ARB_ROUND_ROBIN_EN` conditional so the FSM stays priority-agnostic.
- FSM, wait counter, latched request registers and rdata register live in mem_port_arbiter.

## Test plan
- CPU read alone, MEM_LAT = 1, cpu_addr = 0x10, memory word 0xDEADBEEF -> cpu_ack in cycle T+2 with cpu_rdata = 0xDEADBEEF; dma_ack stays 0; mem_we never 1.
- DMA write, dma_addr = 0x20, dma_wdata = 0x12345678 -> mem_we high for exactly one cycle (T+1) with mem_addr = 0x20; dma_ack at T+2; subsequent CPU read of 0x20 returns 0x12345678.
- Both requesters held high for 6 accesses, `ARB_ROUND_ROBIN_EN` defined -> ack order CPU, DMA, CPU, DMA, CPU, DMA. Undefined -> 6 CPU acks, 0 DMA acks.
- MEM_LAT = 3, CPU read -> busy high for 4 cycles; cpu_ack at T+4; data captured from memory after the third ACCESS cycle.
- rst asserted in the first ACCESS cycle of a DMA write -> mem_we falls in that cycle; no dma_ack; after release, state IDLE and a tie goes to CPU.
- DMA drops dma_req mid-ACCESS -> dma_ack still pulses once; next IDLE with no requests stays IDLE, busy = 0.
